// File: rtl/sr_run_ctrl_pkg.sv
// Shared definitions for the run-control sequencer.
//   runCmdE   : 2-bit command codes carried on cmdOp
//   runStateE : 2-bit sequencer state encodings
//   isWordAligned(): breakpoint address legality test
package sr_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUNCMD_HALT  = 2'd0,
        RUNCMD_RUN   = 2'd1,
        RUNCMD_STEP  = 2'd2,
        RUNCMD_SETBP = 2'd3
    } runCmdE;

    typedef enum logic [1:0] {
        RUNST_HOLD     = 2'd0,
        RUNST_HALTED   = 2'd1,
        RUNST_RUNNING  = 2'd2,
        RUNST_STEPPING = 2'd3
    } runStateE;

    // Width of the shared hold-off / step counter.
    localparam int SEQ_CNT_W = 16;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sr_run_ctrl.sv
// Run-control sequencer for the single-cycle core. Produces cpuEn, the
// enable that qualifies every architectural state update (pc, regfile).
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   cmdValid/Ready  command handshake; accepted when both are high
//   cmdOp           HALT / RUN / STEP / SETBP
//   cmdArg          STEP: [15:0] step count; SETBP: breakpoint byte address
//   pc              current core pc (compared against the breakpoint)
//   cpuEn           core state-update enable
//   halted          high in HOLD and HALTED
//   bpHit           sticky "stopped on breakpoint" flag
//   retireCnt       number of cycles with cpuEn=1, wrapping
module sr_run_ctrl
    import sr_run_ctrl_pkg::*;
#(
    parameter bit RESET_RUN   = 1'b1,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [31:0]      cmdArg,
    input  logic [31:0]      pc,
    output logic             cpuEn,
    output logic             halted,
    output logic             bpHit,
    output logic [CNT_W-1:0] retireCnt
);

    localparam logic [SEQ_CNT_W-1:0] HOLD_LAST = SEQ_CNT_W'(HOLD_CYCLES - 1);
    localparam runStateE             HOLD_EXIT = RESET_RUN ? RUNST_RUNNING : RUNST_HALTED;

    runStateE             state, stateNxt;
    // Counts up during HOLD (elapsed hold-off cycles) and down during
    // STEPPING (instructions still to execute).
    logic [SEQ_CNT_W-1:0] seqCnt, seqCntNxt;
    logic                 bpValid;
    logic [31:0]          bpAddr;
    logic                 skipBp, skipBpNxt;
    logic                 bpHitNxt;
    logic                 bpSet, bpClr;
    logic                 bpMatch;
    logic                 accept;
    runCmdE               op;
    logic [15:0]          stepN;

    assign op       = runCmdE'(cmdOp);
    assign cmdReady = (state != RUNST_HOLD);
    assign accept   = cmdValid & cmdReady;
    // A zero step count still executes one instruction.
    assign stepN    = (cmdArg[15:0] == 16'd0) ? 16'd1 : cmdArg[15:0];
    // skipBp lets a resume at the breakpoint pc execute that instruction.
    assign bpMatch  = bpValid & (pc == bpAddr) & ~skipBp;

    always_comb begin
        stateNxt  = state;
        seqCntNxt = seqCnt;
        skipBpNxt = skipBp;
        bpHitNxt  = bpHit;
        bpSet     = 1'b0;
        bpClr     = 1'b0;
        cpuEn     = 1'b0;
        halted    = 1'b0;

        case (state)
            RUNST_HOLD: begin
                halted = 1'b1;
                if (seqCnt == HOLD_LAST) begin
                    stateNxt  = HOLD_EXIT;
                    seqCntNxt = '0;
                end else begin
                    seqCntNxt = seqCnt + 1'b1;
                end
            end
            RUNST_HALTED: begin
                halted = 1'b1;
            end
            RUNST_RUNNING: begin
                // The breakpointed instruction is held back, not executed.
                cpuEn = ~bpMatch;
                if (bpMatch) begin
                    stateNxt = RUNST_HALTED;
                    bpHitNxt = 1'b1;
                end
            end
            RUNST_STEPPING: begin
                cpuEn = (seqCnt != '0);
                if (cpuEn)
                    seqCntNxt = seqCnt - 1'b1;
                if (seqCnt <= SEQ_CNT_W'(1))
                    stateNxt = RUNST_HALTED;
            end
            default: ;
        endcase

        if (cpuEn)
            skipBpNxt = 1'b0;

        // Accepted commands win over the breakpoint transition; the
        // accept cycle itself keeps the cpuEn computed above.
        if (accept) begin
            case (op)
                RUNCMD_HALT: begin
                    stateNxt = RUNST_HALTED;
                    bpHitNxt = bpHit;
                end
                RUNCMD_RUN: begin
                    stateNxt  = RUNST_RUNNING;
                    bpHitNxt  = 1'b0;
                    skipBpNxt = 1'b1;
                end
                RUNCMD_STEP: begin
                    stateNxt  = RUNST_STEPPING;
                    seqCntNxt = stepN;
                    bpHitNxt  = 1'b0;
                    skipBpNxt = 1'b1;
                end
                RUNCMD_SETBP: begin
                    // Misaligned address doubles as "clear breakpoint".
                    if (isWordAligned(cmdArg))
                        bpSet = 1'b1;
                    else
                        bpClr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUNST_HOLD;
            seqCnt    <= '0;
            bpValid   <= 1'b0;
            bpAddr    <= '0;
            skipBp    <= 1'b0;
            bpHit     <= 1'b0;
            retireCnt <= '0;
        end else begin
            state     <= stateNxt;
            seqCnt    <= seqCntNxt;
            skipBp    <= skipBpNxt;
            bpHit     <= bpHitNxt;
            retireCnt <= retireCnt + {{(CNT_W-1){1'b0}}, cpuEn};
            if (bpSet) begin
                bpValid <= 1'b1;
                bpAddr  <= cmdArg;
            end else if (bpClr) begin
                bpValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_run_ctrl.sv
module tb_sr_run_ctrl;
    import sr_run_ctrl_pkg::*;

    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [1:0]       cmdOp = 2'd0;
    logic [31:0]      cmdArg = 32'd0;
    logic [31:0]      pc = 32'd0;
    logic             cpuEn;
    logic             halted;
    logic             bpHit;
    logic [CNT_W-1:0] retireCnt;

    always #5 clk = ~clk;

    sr_run_ctrl #(.RESET_RUN(1'b1), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdArg(cmdArg), .pc(pc), .cpuEn(cpuEn),
        .halted(halted), .bpHit(bpHit), .retireCnt(retireCnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: mode of the core plus the few facts the rules need.
    localparam int M_HOLD = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;
    int          mMode, mElapsed, mStep;
    bit          mBpOn, mSkip, mHit;
    logic [31:0] mBpAddr, mRet;

    function automatic bit mMatch();
        return mBpOn && (pc == mBpAddr) && !mSkip;
    endfunction

    function automatic bit mEn();
        if (mMode == M_RUN)  return !mMatch();
        if (mMode == M_STEP) return mStep > 0;
        return 1'b0;
    endfunction

    function automatic logic [35:0] expVec();
        return {mEn(), 1'((mMode == M_HOLD) || (mMode == M_HALT)), 1'(mMode != M_HOLD), mHit, mRet};
    endfunction

    task automatic modelReset();
        mMode = M_HOLD; mElapsed = 0; mStep = 0; mBpOn = 0; mBpAddr = 0;
        mSkip = 0; mHit = 0; mRet = 0; pc = 0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        cmdValid = 1'b1; cmdOp = op; cmdArg = arg;
    endtask

    // Hold reset two edges, then release mid-cycle.
    task automatic holdReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Advance the model one clock with the inputs currently driven, then
    // let the emulated core step its pc when it was enabled.
    task automatic advance();
        bit en, match, acc, setHit;
        int nMode;
        en = mEn();
        match = (mMode == M_RUN) && mMatch();
        acc = cmdValid && (mMode != M_HOLD);
        nMode = mMode;
        setHit = 0;
        if (en) begin mRet = mRet + 1; mSkip = 0; end
        if (mMode == M_HOLD) begin
            mElapsed++;
            if (mElapsed == HOLD_CYCLES) nMode = M_RUN;
        end
        if (mMode == M_STEP && en) begin
            mStep--;
            if (mStep == 0) nMode = M_HALT;
        end
        if (match) begin nMode = M_HALT; setHit = 1; end
        if (acc) begin
            case (cmdOp)
                2'd0: begin nMode = M_HALT; setHit = 0; end
                2'd1: begin nMode = M_RUN; mHit = 0; mSkip = 1; setHit = 0; end
                2'd2: begin
                    mStep = (cmdArg[15:0] == 0) ? 1 : int'(cmdArg[15:0]);
                    nMode = M_STEP; mHit = 0; mSkip = 1; setHit = 0;
                end
                default: begin
                    if (cmdArg[1:0] == 2'b00) begin mBpOn = 1; mBpAddr = cmdArg; end
                    else mBpOn = 0;
                end
            endcase
        end
        if (setHit) mHit = 1;
        @(posedge clk);
        #1;
        mMode = nMode;
        cmdValid = 1'b0;
        if (en) pc = (pc + 32'd4) & 32'h3F;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {cpuEn, halted, cmdReady, bpHit, retireCnt},
                     {1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        end
        modelReset();
        holdReset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) cmd(2'd0, 32'd0);  // must be ignored while in HOLD
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL reset_holdoff cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (retireCnt !== 32'd3 || cpuEn !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_run retire=%0d en=%b exp retire=3 en=1", retireCnt, cpuEn);
        end
        advance();
    endtask

    task automatic test_breakpoint();
        bit done;
        rst_n = 1'b0;
        modelReset();
        holdReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            advance();
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) cmd(2'd3, 32'h10);
            else cmd(2'd1, 32'd0);
            done = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                checks++;
                if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                    failures++;
                    $display("FAIL bp_run pass=%0d cyc=%0d got=%h exp=%h", pass, i,
                             {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
                end
                if (pass == 1 && i == 1) begin
                    checks++;
                    if (cpuEn !== 1'b1 || bpHit !== 1'b0) begin
                        failures++;
                        $display("FAIL bp_resume en=%b hit=%b exp en=1 hit=0", cpuEn, bpHit);
                    end
                end
                advance();
                done = (mMode == M_HALT) && (i > 0 || pass == 0);
            end
            @(negedge clk);
            checks++;
            if (!done || halted !== 1'b1 || bpHit !== 1'b1 || cpuEn !== 1'b0 ||
                retireCnt !== (pass == 0 ? 32'd4 : 32'd20)) begin
                failures++;
                $display("FAIL bp_halt pass=%0d done=%b halted=%b hit=%b en=%b retire=%0d exp retire=%0d",
                         pass, done, halted, bpHit, cpuEn, retireCnt, (pass == 0 ? 4 : 20));
            end
            advance();
        end
    endtask

    task automatic test_step();
        int nEn;
        for (int k = 0; k < 2; k++) begin
            cmd(2'd2, (k == 0) ? 32'h0003 : 32'h0000);
            nEn = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                    failures++;
                    $display("FAIL step k=%0d cyc=%0d got=%h exp=%h", k, i,
                             {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
                end
                if (cpuEn === 1'b1) nEn++;
                advance();
            end
            @(negedge clk);
            checks++;
            if (nEn != (k == 0 ? 3 : 1) || halted !== 1'b1) begin
                failures++;
                $display("FAIL step_count k=%0d en_cycles=%0d halted=%b exp en_cycles=%0d halted=1",
                         k, nEn, halted, (k == 0 ? 3 : 1));
            end
            advance();
        end
    endtask

    // Conflict on the breakpoint cycle: k=0 issues HALT, k=1 issues RUN.
    task automatic test_conflict();
        bit hitNow;
        for (int k = 0; k < 2; k++) begin
            hitNow = 0;
            for (int i = 0; i < 40 && !hitNow; i++) begin
                if (mMode == M_HALT) cmd(2'd1, 32'd0);
                else if (mMode == M_RUN && mMatch()) begin
                    cmd((k == 0) ? 2'd0 : 2'd1, 32'd0);
                    hitNow = 1;
                end
                @(negedge clk);
                checks++;
                if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                    failures++;
                    $display("FAIL conflict k=%0d cyc=%0d got=%h exp=%h", k, i,
                             {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
                end
                if (hitNow) begin
                    checks++;
                    if (cpuEn !== 1'b0) begin
                        failures++;
                        $display("FAIL conflict_match_en k=%0d en=%b exp=0", k, cpuEn);
                    end
                end
                advance();
            end
            @(negedge clk);
            checks++;
            if (!hitNow || halted !== (k == 0 ? 1'b1 : 1'b0) || cpuEn !== (k == 0 ? 1'b0 : 1'b1) ||
                bpHit !== 1'b0) begin
                failures++;
                $display("FAIL conflict_after k=%0d found=%b halted=%b en=%b hit=%b exp halted=%0d en=%0d hit=0",
                         k, hitNow, halted, cpuEn, bpHit, (k == 0 ? 1 : 0), (k == 0 ? 0 : 1));
            end
            advance();
        end
    endtask

    task automatic test_bp_clear();
        int nHalt;
        cmd(2'd3, 32'h11);
        nHalt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL bp_clear cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            if (halted !== 1'b0 || cpuEn !== 1'b1) nHalt++;
            advance();
        end
        checks++;
        if (nHalt != 0) begin
            failures++;
            $display("FAIL bp_clear_halts stalled_cycles=%0d exp=0", nHalt);
        end
    endtask

    task automatic test_midreset();
        bit found;
        cmd(2'd2, 32'd20);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL midreset_step cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            advance();
            found = (mMode == M_STEP) && (mStep == 5);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {cpuEn, halted, cmdReady, bpHit, retireCnt} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL midreset_async found=%b got=%h exp=%h", found,
                     {cpuEn, halted, cmdReady, bpHit, retireCnt}, {1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        end
        modelReset();
        holdReset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL midreset_holdoff cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (retireCnt !== 32'd2) begin
            failures++;
            $display("FAIL midreset_retire got=%0d exp=2", retireCnt);
        end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] bpChoices [5];
        bpChoices = '{32'h10, 32'h20, 32'h24, 32'h11, 32'h0};
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: cmd(2'd0, $urandom);
                    1: cmd(2'd1, $urandom);
                    2: cmd(2'd2, {$urandom, 16'(0)} | 32'($urandom_range(6)));
                    default: cmd(2'd3, bpChoices[$urandom_range(4)]);
                endcase
            end
            if ($urandom_range(15) == 0) pc = 32'($urandom_range(15)) * 4;
            @(negedge clk);
            checks++;
            if ({cpuEn, halted, cmdReady, bpHit, retireCnt} !== expVec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i,
                         {cpuEn, halted, cmdReady, bpHit, retireCnt}, expVec());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_step();
        test_conflict();
        test_bp_clear();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
